// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
//   Shared types and reset defaults for the multi-channel LED blinker.
//   mode_t       : per-channel operating mode carried on cfg_mode.
//   cfg_state_t  : config-port handshake state.
//   RST_MODE/ARG : configuration every channel wakes up with (legacy blink).
//   blink_last() : last BLINK phase value for a given half-period argument.
// -----------------------------------------------------------------------------
package blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_t;

   typedef enum logic {
      CFG_IDLE = 1'b0,
      CFG_GAP  = 1'b1
   } cfg_state_t;

   localparam mode_t       RST_MODE = MODE_BLINK;
   localparam int unsigned RST_ARG  = 1;

   // A half-period of 0 behaves like 1, so the terminal phase is max(a,1)-1.
   function automatic int unsigned blink_last(input int unsigned a);
      return (a == 0) ? 0 : a - 1;
   endfunction

endpackage

// File: rtl/blink_chan.sv
// -----------------------------------------------------------------------------
// blink_chan
//   One LED channel: holds mode, argument, phase counter and lit state.
//   Ports:
//     clk, n_rst : clock, synchronous active-low reset
//     tick       : prescaler tick (advances BLINK/PWM phase)
//     sync       : clear phase and lit state, keep mode/arg
//     wr         : load mode/arg from the config port (wins over sync/tick)
//     mode, arg  : config data for a write
//     led        : registered active-low LED pin
// -----------------------------------------------------------------------------
module blink_chan
   import blink_pkg::*;
#(
   parameter int ARGW = 4
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            tick,
   input  logic            sync,
   input  logic            wr,
   input  logic [1:0]      mode,
   input  logic [ARGW-1:0] arg,
   output logic            led
);

   mode_t           mode_q, mode_n;
   logic [ARGW-1:0] arg_q, arg_n;
   logic [ARGW-1:0] phase_q, phase_n;
   logic [ARGW-1:0] last;
   logic            lit_q, lit_n;
   logic            led_n;

   always_comb begin
      mode_n  = mode_q;
      arg_n   = arg_q;
      phase_n = phase_q;
      lit_n   = lit_q;
      last    = ARGW'(blink_last(32'(arg_q)));

      if (wr) begin
         mode_n  = mode_t'(mode);
         arg_n   = arg;
         phase_n = '0;
         lit_n   = 1'b0;
      end else if (sync) begin
         phase_n = '0;
         lit_n   = 1'b0;
      end else if (tick) begin
         case (mode_q)
            MODE_BLINK: begin
               if (phase_q == last) begin
                  phase_n = '0;
                  lit_n   = ~lit_q;
               end else begin
                  phase_n = phase_q + 1'b1;
               end
            end
            MODE_PWM: begin
               // Compare the pre-increment phase so a fresh write gives
               // exactly arg lit ticks starting at the first tick.
               phase_n = phase_q + 1'b1;
               lit_n   = (phase_q < arg_q);
            end
            default: ;
         endcase
      end

      // LED follows the new mode directly so ON/OFF take effect right after
      // the accepting edge, independent of the lit state.
      case (mode_n)
         MODE_OFF: led_n = 1'b1;
         MODE_ON:  led_n = 1'b0;
         default:  led_n = ~lit_n;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         mode_q  <= RST_MODE;
         arg_q   <= ARGW'(RST_ARG);
         phase_q <= '0;
         lit_q   <= 1'b0;
         led     <= 1'b1;
      end else begin
         mode_q  <= mode_n;
         arg_q   <= arg_n;
         phase_q <= phase_n;
         lit_q   <= lit_n;
         led     <= led_n;
      end
   end

endmodule

// File: rtl/blink_multi.sv
// -----------------------------------------------------------------------------
// blink_multi
//   NCH active-low LED channels, each OFF / ON / BLINK / PWM, driven from a
//   shared clk/CDIV prescaler tick and programmed through a valid/ready port.
//   Ports:
//     clk, n_rst : clock, synchronous active-low reset
//     cfg_valid  : config write request (held until accepted)
//     cfg_ready  : port can accept (drops for one cycle after each accept)
//     cfg_ch     : target channel
//     cfg_mode   : mode code (blink_pkg::mode_t)
//     cfg_arg    : BLINK half-period in ticks / PWM duty
//     cfg_err    : one-cycle pulse when an accepted write named cfg_ch >= NCH
//     sync       : realign prescaler and all channel phases
//     led        : LED pins, 0 = lit
// -----------------------------------------------------------------------------
module blink_multi
   import blink_pkg::*;
#(
   parameter  int NCH  = 3,
   parameter  int CDIV = 3,
   parameter  int ARGW = 4,
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [1:0]      cfg_mode,
   input  logic [ARGW-1:0] cfg_arg,
   output logic            cfg_err,
   input  logic            sync,
   output logic [NCH-1:0]  led
);

   localparam int PW = $clog2(CDIV + 1);

   // ---------------- prescaler: 0 after reset/sync, then 1..CDIV ----------
   logic [PW-1:0] pre;
   logic          tick;

   assign tick = (pre == PW'(CDIV));

   always_ff @(posedge clk) begin
      if (!n_rst)      pre <= '0;
      else if (sync)   pre <= '0;
      else if (tick)   pre <= PW'(1);
      else             pre <= pre + 1'b1;
   end

   // ---------------- config handshake ------------------------------------
   cfg_state_t state_q, state_n;
   logic       accept;
   logic       ch_bad;
   logic [NCH-1:0] wr;

   always_ff @(posedge clk) begin
      if (!n_rst) state_q <= CFG_IDLE;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n   = state_q;
      cfg_ready = 1'b0;
      case (state_q)
         CFG_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_n = CFG_GAP;
         end
         CFG_GAP:  state_n = CFG_IDLE;
         default:  state_n = CFG_IDLE;
      endcase
   end

   assign accept = cfg_valid && cfg_ready;
   assign ch_bad = (32'(cfg_ch) >= NCH);

   always_ff @(posedge clk) begin
      if (!n_rst) cfg_err <= 1'b0;
      else        cfg_err <= accept && ch_bad;
   end

   // ---------------- channels --------------------------------------------
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign wr[i] = accept && (cfg_ch == CHW'(i));

      blink_chan #(
         .ARGW (ARGW)
      ) u_chan (
         .clk   (clk),
         .n_rst (n_rst),
         .tick  (tick),
         .sync  (sync),
         .wr    (wr[i]),
         .mode  (cfg_mode),
         .arg   (cfg_arg),
         .led   (led[i])
      );
   end

endmodule

// File: doc/blink_multi.md
Name: blink_multi

Overview:
- Multi-channel successor to the single-rate blinker: NCH active-low LED pins, each independently set to OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- A shared prescaler divides clk by CDIV into a tick.
- A simple valid/ready config port programs each channel at runtime.
- Reset defaults reproduce the legacy behaviour: every LED toggles each CDIV clocks.

Parameters:
- NCH, 3, number of LED channels (>=1).
- CDIV, 3, clocks per prescaler tick (>=1).
- ARGW, 4, width of per-channel argument (BLINK half-period in ticks / PWM duty).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset, sampled on rising clk.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config port can accept.
- cfg_ch  in  CHW=max(1,$clog2(NCH))  target channel.
- cfg_mode  in  2  mode code (blink_pkg::mode_t).
- cfg_arg  in  ARGW  half-period (BLINK) or duty (PWM).
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= NCH.
- sync  in  1  realign prescaler and all channel phases.
- led  out  NCH  LED pins, active low (0 = lit).

Behaviour:
- Reset (n_rst==0 at clk edge) sets:
  - prescaler pre=0, all phases=0, all lit-states=0, led='1.
  - every mode=BLINK, arg=1.
  - cfg_ready=1, cfg_err=0.
- Prescaler:
  - pre increments each clk; pre==CDIV wraps to 1.
  - tick = (pre==CDIV), combinational.
  - Sequence from reset with CDIV=3: 0,1,2,3,1,2,3...
- Channel modes:
  - OFF(0): led=1.
  - ON(1): led=0.
  - BLINK(2): on tick, if phase==max(arg,1)-1 then phase<=0 and lit toggles, else phase++. arg=0 is treated as 1.
  - PWM(3): on tick, phase increments mod 2^ARGW. lit = (phase < arg). arg=0 means always off. Full-on is not reachable; use ON.
- led[i] = ~lit[i], registered. Changes one clk after the tick edge that causes it, matching legacy timing: CDIV=3 gives the first LED-on at clk 4 after reset release.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready.
  - cfg_ready deasserts for exactly the one cycle following an accept, so back-to-back writes take 2 cycles each. cfg_valid is held until accepted.
  - On accept to a valid channel, the next cycle applies: mode/arg updated, phase=0, lit=0 (led=1).
  - In ON mode, led=0 from the cycle after the accept.
  - On accept with cfg_ch>=NCH: no state change; cfg_err=1 for one cycle.
- sync:
  - At the clk edge: pre=0 and every phase=0, lit=0.
  - Mode/arg registers are unchanged.
- Simultaneous events:
  - Accepted write and tick on the same channel: write wins; that tick is ignored for that channel.
  - sync and write in the same cycle: write applies to its channel; sync applies to the prescaler and all other channels.
  - n_rst low overrides everything, including a pending write; cfg_valid during reset is not accepted.
- Widths:
  - phase is ARGW bits.
  - The BLINK compare uses the ARGW-bit arg; max half-period is 2^ARGW-1 ticks.
  - No overflow beyond ARGW wrap in PWM.

Decomposition:
- blink_pkg:
  - mode_t enum (MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_PWM=3).
  - reset defaults RST_MODE=MODE_BLINK, RST_ARG=1.
- Sub-module blink_chan (parameter ARGW):
  - ports: clk, n_rst, tick, sync, wr, mode, arg, led. Holds mode/arg/phase/lit for one channel.
  - blink_multi holds the prescaler, handshake and channel decode, and generates NCH blink_chan instances.

Test Plan:
- Reset/legacy:
  - Stimulus: n_rst low one clk, then high. CDIV=3, default config.
  - Required response: pre=1,2,3 with led='1 (3'b111) for 3 clks, led=3'b000 at clk 4.
  - LED then alternates every 3 clks.
- BLINK period:
  - Stimulus: write ch1 MODE_BLINK arg=2.
  - Required response: led[1]=1 next cycle, toggles every 2 ticks (6 clks). led[0] and led[2] are unaffected.
- PWM:
  - Stimulus: write ch2 MODE_PWM arg=4 (ARGW=4).
  - Required response: led[2]=0 for 4 ticks, then 1 for 12 ticks, repeating every 16 ticks.
  - arg=0 keeps led[2]=1 permanently.
- Handshake/error:
  - Stimulus: hold cfg_valid for two consecutive writes.
  - Required response: cfg_ready pattern is 1,0,1 and each write lands 2 cycles apart.
  - Stimulus: cfg_ch=3 with NCH=3.
  - Required response: cfg_err pulses once and no led changes.
- Collision:
  - Stimulus: write ch0 MODE_ON on a tick cycle, together with sync.
  - Required response: led[0]=0 next cycle. Channels 1 and 2 go led=1 with phase 0, and pre restarts at 0.
- Reset mid-operation:
  - Stimulus: assert n_rst low while in PWM and during a cfg accept.
  - Required response: next clk gives led='1, modes=BLINK arg=1, cfg_ready=1, and the pending write is discarded.
